// File: rtl/isc_square.sv
// isc_square: in-stream unary (stochastic) squarer.
//
// The live input bit is multiplied with a regenerated copy of the input taken
// from a short history shift register at an LFSR-selected tap. The history copy
// is a past, roughly independent sample of the same stream, so P(out=1)=x^2.
//
// Optional build macro:
//   ISC_SQUARE_BIPOLAR_EN - bipolar encoding (value = 2P-1); the product term
//                           becomes XNOR instead of AND.
//
// Parameters:
//   DEPTH  - history length, power of 2 in 2..16
//   LFSR_W - Fibonacci LFSR width, must be >= log2(DEPTH)
//   SEED   - LFSR reset value, must be nonzero
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears all state
//   en    - input bit valid; all state advances only when en=1
//   in    - input stochastic bit
//   out   - squared stochastic bit, registered
//   ready - history full; out is meaningful only when ready=1
module isc_square #(
  parameter int unsigned        DEPTH  = 4,
  parameter int unsigned        LFSR_W = 8,
  parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(8'h5A)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in,
  output logic out,
  output logic ready
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  // Maximal-length Fibonacci feedback taps; bit (t-1) set for polynomial term x^t.
  function automatic logic [LFSR_W-1:0] tap_mask(input int unsigned w);
    logic [31:0] m;
    case (w)
      3:       m = 32'h0006;  // x^3+x^2+1
      4:       m = 32'h000C;  // x^4+x^3+1
      5:       m = 32'h0014;  // x^5+x^3+1
      6:       m = 32'h0030;  // x^6+x^5+1
      7:       m = 32'h0060;  // x^7+x^6+1
      9:       m = 32'h0110;  // x^9+x^5+1
      10:      m = 32'h0240;  // x^10+x^7+1
      11:      m = 32'h0500;  // x^11+x^9+1
      12:      m = 32'h0829;  // x^12+x^6+x^4+x+1
      13:      m = 32'h100D;  // x^13+x^4+x^3+x+1
      14:      m = 32'h2015;  // x^14+x^5+x^3+x+1
      15:      m = 32'h6000;  // x^15+x^14+1
      16:      m = 32'hD008;  // x^16+x^15+x^13+x^4+1
      default: m = 32'h00B8;  // x^8+x^6+x^5+x^4+1
    endcase
    return m[LFSR_W-1:0];
  endfunction

  localparam logic [LFSR_W-1:0] TapMask = tap_mask(LFSR_W);

  logic [DEPTH-1:0]  sr_q, sr_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              out_q, out_d;

  logic [IdxW-1:0]   idx;
  logic              hist_bit;
  logic              prod;

  // Combinational from the counter; no path from in.
  assign ready = (cnt_q == CntW'(DEPTH));
  assign out   = out_q;

  always_comb begin
    sr_d     = sr_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    out_d    = 1'b0;

    // Tap chosen from the pre-update LFSR, read from the pre-shift history.
    idx      = lfsr_q[IdxW-1:0];
    hist_bit = sr_q[idx];

`ifdef ISC_SQUARE_BIPOLAR_EN
    prod     = ~(in ^ hist_bit);
`else
    prod     = in & hist_bit;
`endif

    if (en) begin
      sr_d   = {sr_q[DEPTH-2:0], in};
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TapMask)};
      // Saturate at DEPTH; history keeps sliding once full.
      cnt_d  = ready ? cnt_q : cnt_q + CntW'(1);
      // Gate on the current ready so no partial-history product escapes.
      out_d  = ready & prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      lfsr_q <= SEED;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

endmodule
